// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART blocks.
//   DEF_DATA_BITS  - default data bits per frame
//   DEF_OVERSAMPLE - default tick_16x pulses per bit period
//   BAUD           - nominal line rate
//   SYS_CLK_HZ     - board system clock
//   uart_rx_state_e - receiver FSM state encoding
package uart_pkg;

   localparam int unsigned DEF_DATA_BITS  = 8;
   localparam int unsigned DEF_OVERSAMPLE = 16;
   localparam int unsigned BAUD           = 115200;
   localparam int unsigned SYS_CLK_HZ     = 100_000_000;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk_i     - destination clock
//   rst_ni    - asynchronous active-low reset
//   d_i       - asynchronous input
//   q_o       - synchronized output
// RESET_VAL sets both flops on reset so the output starts at a known line level.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a one-entry output buffer.
//   clk       - system clock
//   reset_n   - asynchronous active-low reset
//   tick_16x  - sample enable, OVERSAMPLE pulses per bit period
//   rx        - asynchronous serial line, idles high
//   rx_data   - received word, LSB first on the wire
//   rx_valid  - rx_data holds an unconsumed word
//   rx_ready  - consumer accepts the word when rx_valid is also high
//   frame_err - one-clk pulse when a stop bit is sampled low
//   overrun   - one-clk pulse when a completed word is dropped (buffer full)
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick_16x,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned TickW = $clog2(OVERSAMPLE);
   localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
   localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

   logic                 rx_s;

   uart_rx_state_e       state_q, state_d;
   logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
   logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 armed_q, armed_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   logic                 frame_done;
   logic                 frame_bad;

   // Resets to idle-high so reset release never looks like a start bit.
   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_rx_sync (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .d_i    (rx),
      .q_o    (rx_s)
   );

   // Receiver FSM: counters and state advance on tick_16x only.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      armed_d    = armed_q;
      frame_done = 1'b0;
      frame_bad  = 1'b0;

      // A held-low line must go high once before another start is accepted.
      if (rx_s) begin
         armed_d = 1'b1;
      end

      if (tick_16x) begin
         case (state_q)
            StIdle: begin
               if (!rx_s && armed_q) begin
                  state_d    = StStart;
                  tick_cnt_d = '0;
               end
            end
            StStart: begin
               if (tick_cnt_q == TickMid) begin
                  tick_cnt_d = '0;
                  if (!rx_s) begin
                     state_d   = StData;
                     bit_cnt_d = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TickW'(1);
               end
            end
            StData: begin
               if (tick_cnt_q == TickLast) begin
                  tick_cnt_d = '0;
                  shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == BitLast) begin
                     state_d = StStop;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BitW'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TickW'(1);
               end
            end
            StStop: begin
               if (tick_cnt_q == TickLast) begin
                  tick_cnt_d = '0;
                  state_d    = StIdle;
                  if (rx_s) begin
                     frame_done = 1'b1;
                  end else begin
                     frame_bad = 1'b1;
                     armed_d   = 1'b0;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TickW'(1);
               end
            end
            default: begin
               state_d    = StIdle;
               tick_cnt_d = '0;
            end
         endcase
      end
   end

   // Output buffer and flag pulses act on every clk.
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = frame_bad;
      overrun_d   = 1'b0;

      if (frame_done) begin
         // A consume in the same cycle frees the slot for the new word.
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         armed_q     <= 1'b1;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         armed_q     <= armed_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus pushes expected events
// (word presented, frame error, overrun) into a queue; a monitor pops and
// compares whenever the DUT presents one of those events.
module tb_uart_rx;

   localparam int unsigned BitClks = 64;  // 16 ticks x 4 clk per tick

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       tick_16x = 1'b0;
   logic       rx       = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   uart_rx #(
      .DATA_BITS  (8),
      .OVERSAMPLE (16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick_16x  (tick_16x),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // One tick every 4 clk, changed on the falling edge.
   initial begin
      forever begin
         repeat (3) @(negedge clk);
         tick_16x = 1'b1;
         @(negedge clk);
         tick_16x = 1'b0;
      end
   end

   typedef enum int {EvData, EvFerr, EvOvr} ev_kind_e;
   typedef struct {
      ev_kind_e   kind;
      logic [7:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  last_run = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push_ev(input ev_kind_e kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic expect_ev(input ev_kind_e kind, input logic [7:0] data);
      ev_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got %s/%02h at %0t, expected none",
                  kind.name(), data, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind == EvData && e.data !== data)) begin
            n_fail++;
            $display("FAIL scoreboard: got %s/%02h at %0t, expected %s/%02h",
                     kind.name(), data, $time, e.kind.name(), e.data);
         end
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      logic last_valid;
      int   run;
      last_valid = 1'b0;
      run        = 0;
      forever begin
         @(posedge clk);
         #1;
         if (frame_err === 1'b1) expect_ev(EvFerr, 8'h00);
         if (overrun === 1'b1) expect_ev(EvOvr, 8'h00);
         // New word: valid now, and not merely held from an unaccepted cycle.
         if (rx_valid === 1'b1 && (!last_valid || rx_ready)) expect_ev(EvData, rx_data);
         if (rx_valid === 1'b1) begin
            run++;
         end else if (last_valid) begin
            last_run = run;
            run      = 0;
         end
         last_valid = (rx_valid === 1'b1) && reset_n;
      end
   end

   // Start bit lands two clk before a tick edge, giving a fixed sampling phase:
   // stop bit is sampled 34 clk after the stop bit starts.
   task automatic align();
      do @(posedge clk); while (tick_16x !== 1'b1);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input bit pulse_ready);
      align();
      rx = 1'b0;
      repeat (BitClks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BitClks) @(negedge clk);
      end
      rx = stop;
      for (int c = 1; c <= BitClks; c++) begin
         @(negedge clk);
         if (pulse_ready && c == 34) rx_ready = 1'b1;
         if (pulse_ready && c == 35) rx_ready = 1'b0;
      end
      rx = 1'b1;
   endtask

   task automatic consume();
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      // Reset state
      repeat (5) @(negedge clk);
      check("rst_valid", {31'd0, rx_valid}, 0);
      check("rst_data", {24'd0, rx_data}, 0);
      check("rst_ferr", {31'd0, frame_err}, 0);
      check("rst_ovr", {31'd0, overrun}, 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      // Single byte, consumer always ready
      rx_ready = 1'b1;
      push_ev(EvData, 8'h55);
      send_frame(8'h55, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      drain("s1_drain");
      check("s1_valid_len", last_run, 1);
      check("s1_data_hold", {24'd0, rx_data}, 32'h55);
      rx_ready = 1'b0;

      // Back-to-back with no consumer: second frame overruns
      push_ev(EvData, 8'hA3);
      send_frame(8'hA3, 1'b1, 1'b0);
      push_ev(EvOvr, 8'h00);
      send_frame(8'h0F, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      drain("s2_drain");
      check("s2_data", {24'd0, rx_data}, 32'hA3);
      check("s2_valid", {31'd0, rx_valid}, 1);
      consume();
      check("s2_valid_clr", {31'd0, rx_valid}, 0);
      check("s2_data_keep", {24'd0, rx_data}, 32'hA3);

      // Framing error, then a good frame
      push_ev(EvFerr, 8'h00);
      send_frame(8'hC4, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      drain("s3_drain_ferr");
      check("s3_valid", {31'd0, rx_valid}, 0);
      push_ev(EvData, 8'h12);
      send_frame(8'h12, 1'b1, 1'b0);
      drain("s3_drain_data");
      check("s3_data", {24'd0, rx_data}, 32'h12);
      consume();

      // False start: 4-tick glitch
      align();
      rx = 1'b0;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      repeat (800) @(negedge clk);
      check("s4_valid", {31'd0, rx_valid}, 0);

      // Simultaneous consume and completion
      push_ev(EvData, 8'h81);
      send_frame(8'h81, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      push_ev(EvData, 8'h7E);
      send_frame(8'h7E, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      drain("s5_drain");
      check("s5_data", {24'd0, rx_data}, 32'h7E);
      check("s5_valid", {31'd0, rx_valid}, 1);
      consume();

      // Reset during data bit 3, then a clean frame
      align();
      rx = 1'b0;
      repeat (BitClks) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 1'b1;
         repeat (BitClks) @(negedge clk);
      end
      rx = 1'b0;
      repeat (32) @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("s6_rst_valid", {31'd0, rx_valid}, 0);
      check("s6_rst_ferr", {31'd0, frame_err}, 0);
      check("s6_rst_ovr", {31'd0, overrun}, 0);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (700) @(negedge clk);
      check("s6_valid", {31'd0, rx_valid}, 0);
      push_ev(EvData, 8'h3C);
      send_frame(8'h3C, 1'b1, 1'b0);
      drain("s6_drain");
      check("s6_data", {24'd0, rx_data}, 32'h3C);
      consume();

      // Break: one frame error only, no restart until the line goes high
      push_ev(EvFerr, 8'h00);
      align();
      rx = 1'b0;
      repeat (1500) @(negedge clk);
      rx = 1'b1;
      repeat (100) @(negedge clk);
      drain("s7_drain_ferr");
      push_ev(EvData, 8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0);
      drain("s7_drain_data");
      check("s7_data", {24'd0, rx_data}, 32'h5A);
      consume();

      repeat (50) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16: tick_16x pulses per bit period; must be an even value >= 4.
REQ-003 Port clk, input, 1: single system clock (100 MHz on board); every flop uses its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port tick_16x, input, 1: single-cycle sample enable at OVERSAMPLE x baud rate (1,843,200 Hz at 115200 baud); it is a clk enable, never a clock.
REQ-006 Port rx, input, 1: asynchronous serial line; idles high.
REQ-007 Port rx_data, output, DATA_BITS: received byte, LSB first on the wire.
REQ-008 Port rx_valid, output, 1: rx_data holds an unconsumed byte.
REQ-009 Port rx_ready, input, 1: consumer accepts the byte when rx_valid and rx_ready are both high on a clk edge.
REQ-010 Port frame_err, output, 1: one-clk pulse when a stop bit is sampled low.
REQ-011 Port overrun, output, 1: one-clk pulse when a completed byte is dropped because the buffer is still full.

Function
REQ-012 rx shall pass through a 2-flop synchronizer before any use; all sampling decisions use the synchronized value only.
REQ-013 FSM states shall be IDLE, START, DATA and STOP.
REQ-014 Tick counter: counts tick_16x pulses within a bit; range 0..OVERSAMPLE-1; wraps to 0.
REQ-015 Bit counter: counts data bits; range 0..DATA_BITS-1.
REQ-016 IDLE: a synchronized rx of 0 on a tick_16x cycle moves the FSM to START and clears the tick counter.
REQ-017 START: on the tick where the tick counter reaches OVERSAMPLE/2-1 (mid-bit):
- rx=0 moves to DATA and clears the tick counter and bit counter.
- rx=1 is a false start and returns to IDLE with no outputs asserted.
REQ-018 DATA: on every tick where the tick counter reaches OVERSAMPLE-1, rx is shifted into the MSB of a shift register (right shift).
- After bit DATA_BITS-1 the FSM moves to STOP.
REQ-019 STOP: on the tick where the tick counter reaches OVERSAMPLE-1:
- rx=1 marks the frame complete.
- rx=0 pulses frame_err for one clk and discards the byte.
- Either way the FSM returns to IDLE.
REQ-020 Frame complete with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle: load rx_data from the shift register and set rx_valid=1 on the next edge.
REQ-021 Frame complete with rx_valid=1 and rx_ready=0: pulse overrun for one clk; rx_data and rx_valid stay unchanged.
REQ-022 rx_ready with rx_valid=1 and no completion in that cycle clears rx_valid on the next edge; rx_data holds its value.
REQ-023 rx_ready while rx_valid=0 shall have no effect.
REQ-024 Counters and FSM shall advance only on tick_16x cycles; rx_valid, rx_ready handling and the flag pulses act on any clk.
REQ-025 Latency: rx_valid rises exactly one clk after the tick that samples a valid stop bit.
REQ-026 A break condition (rx held low) produces a frame_err pulse, then the FSM rearms at IDLE; no new start is detected until rx has been seen high at least once.

Reset
REQ-027 reset_n low shall asynchronously force FSM=IDLE, all counters=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0 and overrun=0.
REQ-028 Both synchronizer flops shall reset to 1 (line idle) so that release of reset never fakes a start bit.
REQ-029 Reset asserted mid-frame shall abandon the frame without any valid, frame_err or overrun output.

Structure
REQ-030 A shared package uart_pkg shall hold the FSM state enumeration and the default constants (DATA_BITS=8, OVERSAMPLE=16, BAUD=115200, SYS_CLK_HZ=100_000_000).
REQ-031 The synchronizer shall be a separate sub-module sync_2ff, reusable by the future uart_tx and other blocks.
REQ-032 tick_16x shall come from an external tick generator and shall not be generated inside uart_rx.

Verification
REQ-033 Bench clock and tick: tick_16x shall pulse once every 4 clk in all scenarios.
REQ-034 Scenario, single byte: 0x55 sent with rx_ready held 1 -> rx_data=0x55, rx_valid high 1 clk after the stop-bit tick, then low the next clk.
REQ-035 Scenario, back-to-back frames: 0xA3 then 0x0F with rx_ready=0 -> rx_data=0xA3 is retained and overrun pulses once at the end of the second frame.
REQ-036 Scenario, framing error: 0xC4 sent with a low stop bit -> frame_err pulses once, rx_valid stays 0, and the next frame 0x12 is received correctly.
REQ-037 Scenario, false start: a 4-tick low glitch on rx -> FSM returns to IDLE with no outputs asserted.
REQ-038 Scenario, simultaneous consume: rx_ready asserted in the same clk as completion of 0x7E while 0x81 is pending -> 0x81 is consumed, rx_data=0x7E, rx_valid stays 1, no overrun.
REQ-039 Scenario, reset mid-frame: reset_n pulsed low during data bit 3, then 0x3C sent -> no flags during the reset, and 0x3C is received cleanly afterwards.
